// File: rtl/spi_receive_mode_if.sv
// Consumer-side bundle of the SPI receiver: head-of-FIFO words, handshake and status pulses.
// The receiver drives the master modport; the word consumer uses the slave modport.
interface spi_receive_mode_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 1
);
  logic [DATA_WIDTH-1:0] data_out [LINES];
  logic                  data_valid_out;
  logic                  data_ready_in;
  logic [15:0]           word_count_out;
  logic                  overflow_out;
  logic                  frame_error_out;

  modport master (
    output data_out, data_valid_out, word_count_out, overflow_out, frame_error_out,
    input  data_ready_in
  );

  modport slave (
    input  data_out, data_valid_out, word_count_out, overflow_out, frame_error_out,
    output data_ready_in
  );
endinterface

// File: rtl/spi_receive_mode.sv
// Multi-line SPI receiver: synchronises DCLK/CS/CIPO into clk_in, assembles words on the
// configured sampling edge and buffers them in a show-ahead FIFO with a valid/ready output.
module spi_receive_mode #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 1,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [LINES-1:0]  chip_data_in,
  input  logic              chip_clk_in,
  input  logic              chip_sel_in,
  spi_receive_mode_if.master rx
);

  localparam int CW    = $clog2(DATA_WIDTH);
  localparam int AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW    = LINES * DATA_WIDTH;
  localparam logic             IDLE_CLK    = (CPOL != 0);
  localparam logic             SAMPLE_RISE = (CPOL == CPHA);
  localparam logic [CW-1:0]    LAST_BIT    = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]      FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchronisers: [0] first flop, [1] second flop, [2] delay for edge detection.
  logic [2:0]        dclk_sync;
  logic [1:0]        cs_sync;
  logic [LINES-1:0]  din_s1, din_s2, din_s3;
  logic [1:0]        sync_fill;
  logic              cs_armed;
  logic              sample_edge, sample_q;

  state_t            state_q, state_d;
  logic              frame_start, frame_abort, shift_en, word_done;
  logic [CW-1:0]     bit_cnt_q;
  logic [15:0]       word_count_q;
  logic [DATA_WIDTH-1:0] shift_q [LINES];
  logic [DATA_WIDTH-1:0] shift_d [LINES];
  logic [WW-1:0]     word_flat;

  logic [WW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              full, valid, pop, wr_ok;
  logic              overflow_q, frame_err_q;
  logic [WW-1:0]     head_word;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dclk_sync <= {3{IDLE_CLK}};
      cs_sync   <= 2'b11;
      din_s1    <= '0;
      din_s2    <= '0;
      din_s3    <= '0;
      sync_fill <= 2'b00;
      cs_armed  <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[1:0], chip_clk_in};
      cs_sync   <= {cs_sync[0], chip_sel_in};
      din_s1    <= chip_data_in;
      din_s2    <= din_s1;
      din_s3    <= din_s2;
      sync_fill <= {sync_fill[0], 1'b1};
      // Only a CS-high level seen after the synchronisers refill may arm the next frame.
      if (sync_fill[1] && cs_sync[1]) cs_armed <= 1'b1;
      sample_q  <= sample_edge;
    end
  end

  // The registered edge lines up with din_s3, which holds the data captured alongside it.
  assign sample_edge = SAMPLE_RISE ? (dclk_sync[1] & ~dclk_sync[2])
                                   : (~dclk_sync[1] & dclk_sync[2]);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_armed && !cs_sync[1]) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_sync[1]) begin
          state_d     = IDLE;
          frame_abort = (bit_cnt_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_en  = (state_q == ACTIVE) && (state_d == ACTIVE) && sample_q;
  assign word_done = shift_en && (bit_cnt_q == LAST_BIT);

  always_comb begin
    word_flat = '0;
    for (int l = 0; l < LINES; l++) begin
      if (MSB_FIRST != 0) shift_d[l] = {shift_q[l][DATA_WIDTH-2:0], din_s3[l]};
      else                shift_d[l] = {din_s3[l], shift_q[l][DATA_WIDTH-1:1]};
      word_flat[l*DATA_WIDTH +: DATA_WIDTH] = shift_d[l];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_count_q <= '0;
      frame_err_q  <= 1'b0;
      for (int l = 0; l < LINES; l++) shift_q[l] <= '0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_abort;
      if (frame_start) begin
        bit_cnt_q    <= '0;
        word_count_q <= '0;
      end else if (shift_en) begin
        for (int l = 0; l < LINES; l++) shift_q[l] <= shift_d[l];
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
        if (word_done && word_count_q != 16'hFFFF) word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  // Show-ahead FIFO: the head entry is presented combinationally whenever it is non-empty.
  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_COUNT);
  assign pop   = valid && rx.data_ready_in;
  assign wr_ok = word_done && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= word_done && full && !pop;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the count gates it, so stale entries are never visible.
  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr_q] <= word_flat;
  end

  assign head_word = mem[rd_ptr_q];

  for (genvar g = 0; g < LINES; g++) begin : g_out
    assign rx.data_out[g] = valid ? head_word[g*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign rx.data_valid_out  = valid;
  assign rx.word_count_out  = word_count_q;
  assign rx.overflow_out    = overflow_q;
  assign rx.frame_error_out = frame_err_q;

endmodule

// File: tb/tb_spi_receive_mode.sv
// Drives one SPI pin stream into four receivers (modes 0..3, one LSB-first) and scoreboards
// each receiver's output words against a bit-sequence reference model.
module tb_spi_receive_mode;
  localparam int N_DUT = 4;
  localparam int DEPTH = 4;
  localparam int H     = 4;  // clk cycles per DCLK half-phase

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs  = 1'b1;
  logic tog = 1'b0;          // 1 between leading and trailing DCLK edge
  logic d0 = 1'b0, d1 = 1'b0;
  logic ready_drv = 1'b1, rnd_en = 1'b0, rnd_bit = 1'b0;
  logic ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int ovf_exp = 0;
  int ferr_exp = 0;

  logic [15:0] exp_q [N_DUT][$];
  logic        valid_a [N_DUT];
  logic [15:0] wc_a    [N_DUT];
  logic [7:0]  head0_a [N_DUT];
  int          ovf_cnt  [N_DUT];
  int          ferr_cnt [N_DUT];
  int          rise_cyc [N_DUT];
  int          fall_cyc [N_DUT];

  assign ready = rnd_en ? rnd_bit : ready_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(1, 0));
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int L  = (gi == 0) ? 1 : 2;
    localparam int CP = gi / 2;
    localparam int CH = gi % 2;
    localparam int MF = (gi == 3) ? 0 : 1;

    logic         dclk;
    logic [L-1:0] din;
    assign dclk = (CP != 0) ^ tog;
    assign din  = L'({d1, d0});

    spi_receive_mode_if #(.DATA_WIDTH(8), .LINES(L)) bus ();
    assign bus.data_ready_in = ready;

    spi_receive_mode #(
      .DATA_WIDTH(8), .LINES(L), .CPOL(CP), .CPHA(CH), .MSB_FIRST(MF), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk_in       (clk),
      .rst_in       (rst),
      .chip_data_in (din),
      .chip_clk_in  (dclk),
      .chip_sel_in  (cs),
      .rx           (bus)
    );

    assign valid_a[gi] = bus.data_valid_out;
    assign wc_a[gi]    = bus.word_count_out;
    assign head0_a[gi] = bus.data_out[0];

    initial begin : monitor
      logic        pv, pready, prst;
      logic [15:0] pdata, got, exp;
      pv = 1'b0; pready = 1'b0; prst = 1'b1; pdata = '0;
      forever begin
        @(negedge clk);
        got = {bus.data_out[L-1], bus.data_out[0]};
        if (bus.data_valid_out && !pv) rise_cyc[gi] = cyc;
        if (!bus.data_valid_out && pv) fall_cyc[gi] = cyc;
        if (pv && !pready && !prst) begin
          check($sformatf("rx%0d_stable_valid", gi), 32'(bus.data_valid_out), 32'd1);
          check($sformatf("rx%0d_stable_data", gi), 32'(got), 32'(pdata));
        end
        if (bus.overflow_out)    ovf_cnt[gi]++;
        if (bus.frame_error_out) ferr_cnt[gi]++;
        if (bus.data_valid_out && ready && !rst) begin
          if (exp_q[gi].size() == 0) begin
            check($sformatf("rx%0d_unexpected_word", gi), 32'(got), 32'hFFFF_FFFF);
          end else begin
            exp = exp_q[gi].pop_front();
            check($sformatf("rx%0d_word", gi), 32'(got), 32'(exp));
          end
        end
        pv = bus.data_valid_out; pready = ready; prst = rst; pdata = got;
      end
    end
  end

  // Word each receiver should assemble from a transmitted bit sequence (seq[7] goes first).
  function automatic logic [15:0] model_word(input int inst, input logic [7:0] s0, input logic [7:0] s1);
    int         w [2];
    int         b;
    logic [7:0] seq [2];
    seq[0] = s0; seq[1] = s1;
    for (int l = 0; l < 2; l++) begin
      w[l] = 0;
      for (int k = 0; k < 8; k++) begin
        b = int'(seq[l][7-k]);
        if (inst == 3) w[l] = w[l] + (b << k);
        else           w[l] = w[l] * 2 + b;
      end
    end
    if (inst == 0) w[1] = w[0];
    return {8'(w[1]), 8'(w[0])};
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N_DUT; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] s0, input logic [7:0] s1, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      d0 = s0[7-k]; d1 = s1[7-k];
      step(H); tog = 1'b1; edge_cyc = cyc;
      step(H); tog = 1'b0;
      step(H);
    end
  endtask

  task automatic send_word(input logic [7:0] s0, input logic [7:0] s1);
    if (exp_q[0].size() >= DEPTH) ovf_exp++;
    else for (int i = 0; i < N_DUT; i++) exp_q[i].push_back(model_word(i, s0, s1));
    send_bits(s0, s1, 8);
  endtask

  task automatic begin_frame();
    cs = 1'b0;
    step(2 * H);
  endtask

  task automatic end_frame();
    step(H);
    cs = 1'b1;
    step(3 * H);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("drain", 32'(pending()), 32'd0);
  endtask

  task automatic check_all(input string name, input int sel, input logic [31:0] exp);
    for (int i = 0; i < N_DUT; i++) begin
      case (sel)
        0:       check($sformatf("rx%0d_%s", i, name), 32'(valid_a[i]), exp);
        1:       check($sformatf("rx%0d_%s", i, name), 32'(wc_a[i]), exp);
        2:       check($sformatf("rx%0d_%s", i, name), 32'(head0_a[i]), exp);
        3:       check($sformatf("rx%0d_%s", i, name), 32'(ovf_cnt[i]), exp);
        default: check($sformatf("rx%0d_%s", i, name), 32'(ferr_cnt[i]), exp);
      endcase
    end
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    check_all("reset_valid", 0, 0);
    check_all("reset_wc", 1, 0);
    check_all("reset_data", 2, 0);

    // Single word with ready high; latency measured on the mode-0 receiver.
    begin_frame();
    send_word(8'hA5, 8'h5A);
    end_frame();
    check("rx0_latency", 32'(rise_cyc[0] - edge_cyc), 32'd4);
    check("rx0_valid_width", 32'(fall_cyc[0] - rise_cyc[0]), 32'd1);
    check_all("wc_single", 1, 1);

    // Fixed two-line pattern, then a sequence whose first bit alone is set.
    begin_frame();
    send_word(8'h3C, 8'hC3);
    send_word(8'h80, 8'h80);
    end_frame();
    drain(200);
    check_all("wc_pattern", 1, 2);

    // Random words with a randomly toggling consumer.
    rnd_en = 1'b1;
    begin_frame();
    for (int n = 0; n < 6; n++) send_word(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    end_frame();
    drain(400);
    rnd_en = 1'b0;
    check_all("wc_random", 1, 6);

    // Five words into a four-deep FIFO with the consumer stalled.
    ready_drv = 1'b0;
    begin_frame();
    for (int n = 1; n <= 5; n++) send_word(8'(n * 17), 8'($urandom_range(255, 0)));
    end_frame();
    check_all("overflow_count", 3, 32'(ovf_exp));
    check_all("wc_overflow", 1, 5);
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("rx%0d_held_head", i), 32'(head0_a[i]), 32'(exp_q[i][0][7:0]));
    ready_drv = 1'b1;
    drain(200);
    check_all("overflow_after_drain", 3, 32'(ovf_exp));

    // CS raised after five bits, then a clean frame.
    begin_frame();
    send_bits(8'hF0, 8'h0F, 5);
    end_frame();
    ferr_exp++;
    check_all("frame_error", 4, 32'(ferr_exp));
    check_all("no_partial_word", 0, 0);
    begin_frame();
    send_word(8'h7E, 8'h81);
    end_frame();
    drain(200);
    check_all("wc_after_error", 1, 1);

    // Reset with two words buffered and three bits pending; CS stays low afterwards.
    ready_drv = 1'b0;
    begin_frame();
    send_word(8'hC5, 8'h5C);
    send_word(8'h39, 8'h93);
    send_bits(8'hAA, 8'h55, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_all("rst_valid", 0, 0);
    check_all("rst_wc", 1, 0);
    check_all("rst_data", 2, 0);
    for (int i = 0; i < N_DUT; i++) exp_q[i].delete();
    ready_drv = 1'b1;
    send_bits(8'h6B, 8'hB6, 8);
    step(10);
    check_all("no_word_after_rst", 0, 0);
    check_all("wc_after_rst", 1, 0);
    check_all("no_ferr_on_rst", 4, 32'(ferr_exp));
    end_frame();
    begin_frame();
    send_word(8'h96, 8'h69);
    end_frame();
    drain(200);
    check_all("wc_resume", 1, 1);

    check("all_words_seen", 32'(pending()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_receive_mode.md
SPI_RECEIVE_MODE -- requirements
Module: spi_receive_mode

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, meaning bits per received word per line (legal range 2..32).
REQ-002 The block SHALL expose parameter LINES, default 1, meaning number of parallel data lines sharing one DCLK/CS.
REQ-003 The block SHALL expose parameter CPOL, default 0, meaning DCLK idle level.
REQ-004 The block SHALL expose parameter CPHA, default 0, meaning 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 The block SHALL expose parameter MSB_FIRST, default 1, meaning 1 = first bit lands in bit DATA_WIDTH-1, 0 = first bit lands in bit 0.
REQ-006 The block SHALL expose parameter FIFO_DEPTH, default 4, meaning output word buffer depth (power of two, at least 2).
REQ-007 clk_in  input  1  system clock (100 MHz); one clock; all logic on its rising edge.
REQ-008 rst_in  input  1  reset, synchronous and active-high.
REQ-009 chip_data_in  input  LINES  CIPO data lines, asynchronous to clk_in.
REQ-010 chip_clk_in  input  1  DCLK, asynchronous, at most clk_in/8.
REQ-011 chip_sel_in  input  1  CS, active low, asynchronous.
REQ-012 data_out  output  LINES x DATA_WIDTH (unpacked array by line)  head-of-FIFO word, one entry per line.
REQ-013 data_valid_out  output  1  data_out holds an unread word.
REQ-014 data_ready_in  input  1  consumer accepts; a word pops when data_valid_out and data_ready_in are both high.
REQ-015 word_count_out  output  16  words completed in the current or most recent frame.
REQ-016 overflow_out  output  1  one-cycle pulse: completed word dropped because FIFO was full.
REQ-017 frame_error_out  output  1  one-cycle pulse: CS deasserted with a partial word pending.

Function
REQ-018 chip_clk_in, chip_sel_in and chip_data_in SHALL each pass through a 2-flop synchroniser; edge detection SHALL compare sync stage 2 against a third delay register.
REQ-019 Sampling edge SHALL be rising DCLK when CPOL==CPHA and falling DCLK otherwise; non-sampling edges SHALL be ignored.
REQ-020 FSM states: IDLE (CS high), ACTIVE (CS low); IDLE->ACTIVE on synchronised CS low; ACTIVE->IDLE on synchronised CS high.
REQ-021 On IDLE->ACTIVE, bit counter SHALL clear to 0 and word_count_out SHALL clear to 0.
REQ-022 In ACTIVE, on each detected sampling edge, every line SHALL shift in its synchronised data bit (left shift if MSB_FIRST, right shift otherwise) and the bit counter SHALL increment.
REQ-023 On the sampling edge where bit counter == DATA_WIDTH-1, the assembled word (including that bit) SHALL be written to the FIFO in the same cycle, the counter SHALL wrap to 0 and word_count_out SHALL increment (saturating at 0xFFFF).
REQ-024 FIFO SHALL be show-ahead: data_valid_out SHALL rise the cycle after the write into an empty FIFO, giving 4 clk_in cycles from the final sampling pin edge to data_valid_out.
REQ-025 Write with FIFO full and no simultaneous pop SHALL drop the new word, keep FIFO contents and pulse overflow_out; a write and pop in the same cycle with FIFO full SHALL both succeed.
REQ-026 data_out and data_valid_out SHALL remain stable while data_valid_out is high and data_ready_in is low.
REQ-027 ACTIVE->IDLE with bit counter != 0 SHALL discard the partial word and pulse frame_error_out once; with counter == 0 no pulse.
REQ-028 The FIFO SHALL be unaffected by CS transitions; buffered words SHALL remain poppable in IDLE.

Reset
REQ-029 While rst_in is high on a clk_in edge: FSM=IDLE, bit counter=0, shift registers=0, FIFO empty, data_out all 0, data_valid_out=0, word_count_out=0, overflow_out=0, frame_error_out=0, synchroniser and delay flops loaded with idle values (DCLK=CPOL, CS=1).
REQ-030 Reset mid-frame SHALL discard all partial and buffered data without pulsing frame_error_out; after release, reception SHALL resume only after a fresh CS falling edge.

Verification
REQ-031 Mode 0, LINES=1, MSB_FIRST=1: send 0xA5 with ready high -> data_out[0]=0xA5, data_valid_out high for exactly 1 cycle, 4 cycles after the 8th rising DCLK edge, word_count_out=1.
REQ-032 Modes 1, 2, 3 each with LINES=2, send 0x3C/0xC3 -> data_out[0]=0x3C, data_out[1]=0xC3 in every mode; with MSB_FIRST=0 on a 0x01 bit sequence (first bit 1) -> 0x01.
REQ-033 FIFO_DEPTH=4, ready low, 5 words 0x11..0x55 in one frame -> overflow_out pulses once on the 5th word; then ready high pops 0x11, 0x22, 0x33, 0x44 in order; word_count_out=5.
REQ-034 CS raised after 5 of 8 bits -> frame_error_out pulses once, no FIFO write; next frame sends 0x7E -> 0x7E received intact.
REQ-035 rst_in asserted for 1 cycle after 3 bits with 2 words buffered -> data_valid_out=0 next cycle; DCLK edges continuing with CS still low produce no words until CS toggles high then low.
